guess_checker: RTL

//   Scores the player's 4-digit hex guess (from the switch-entry stage's playerInput/finished)

---
 rtl/guess_checker.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/guess_checker.sv
// guess_checker: scores a 4-digit hex guess against the round secret.
// Exact matches are counted in 4 cycles, then partial matches in a fixed
// 16-cycle pairwise sweep that uses "used" masks so duplicate digits are
// never double-counted. Tracks tries per round and raises sticky win/lose.
module guess_checker #(
    parameter int MAX_TRIES = 8,
    parameter int TRY_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      secret,
    input  logic             secret_valid,
    input  logic [15:0]      guess,
    input  logic             guess_done,
    output logic             busy,
    output logic             result_valid,
    output logic [2:0]       exact_cnt,
    output logic [2:0]       partial_cnt,
    output logic [TRY_W-1:0] tries,
    output logic             win,
    output logic             lose
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READY  = 3'd1,
        EXACT  = 3'd2,
        PART   = 3'd3,
        RESULT = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [TRY_W-1:0] MAX_T = TRY_W'(MAX_TRIES);

    state_t      state_reg, state_next;
    logic [15:0] sec_reg, gue_reg;
    logic [3:0]  cnt_reg;
    logic [3:0]  sec_used_reg, gue_used_reg;
    logic [2:0]  sync_reg;

    logic [3:0]  sec_dig [4];
    logic [3:0]  gue_dig [4];

    // Split the latched words into digit lanes
    for (genvar gi = 0; gi < 4; gi++) begin : g_dig
        assign sec_dig[gi] = sec_reg[4*gi +: 4];
        assign gue_dig[gi] = gue_reg[4*gi +: 4];
    end

    // guess_done is asynchronous: two flops to resynchronise, a third to find the rising edge
    logic guess_ev;
    assign guess_ev = sync_reg[1] & ~sync_reg[2];

    // In EXACT cnt_reg[1:0] is the slot; in PART cnt_reg[3:2] is secret slot i, [1:0] guess slot j
    logic [1:0] pi, pj;
    logic       exact_hit, part_hit;
    assign pi        = cnt_reg[3:2];
    assign pj        = cnt_reg[1:0];
    assign exact_hit = (gue_dig[pj] == sec_dig[pj]);
    assign part_hit  = !sec_used_reg[pi] && !gue_used_reg[pj] && (sec_dig[pi] == gue_dig[pj]);

    // Round outcome computed from the finished counts while in RESULT
    logic [TRY_W-1:0] tries_inc;
    logic             win_next, lose_next;
    assign tries_inc = (tries == MAX_T) ? tries : tries + TRY_W'(1);
    assign win_next  = (exact_cnt == 3'd4);
    assign lose_next = !win_next && (tries_inc == MAX_T);

    // Synchronizer for the entry-complete level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_reg <= 3'b000;
        else      sync_reg <= {sync_reg[1:0], guess_done};
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic; a new secret restarts the round from any state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = IDLE;
            READY:   if (guess_ev) state_next = EXACT;
            EXACT:   if (cnt_reg[1:0] == 2'd3) state_next = PART;
            PART:    if (cnt_reg == 4'd15) state_next = RESULT;
            RESULT:  state_next = (win_next || lose_next) ? DONE : READY;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (secret_valid) state_next = READY;
    end

    // Moore outputs decoded from state
    always_comb begin
        busy = (state_reg == EXACT) || (state_reg == PART) || (state_reg == RESULT);
    end

    // Scoring datapath: latches, match masks, counters and round status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_reg      <= '0;
            gue_reg      <= '0;
            cnt_reg      <= '0;
            sec_used_reg <= '0;
            gue_used_reg <= '0;
            result_valid <= 1'b0;
            exact_cnt    <= '0;
            partial_cnt  <= '0;
            tries        <= '0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (secret_valid) begin
                sec_reg      <= secret;
                cnt_reg      <= '0;
                sec_used_reg <= '0;
                gue_used_reg <= '0;
                exact_cnt    <= '0;
                partial_cnt  <= '0;
                tries        <= '0;
                win          <= 1'b0;
                lose         <= 1'b0;
            end else begin
                case (state_reg)
                    READY: begin
                        if (guess_ev) begin
                            gue_reg      <= guess;
                            cnt_reg      <= '0;
                            sec_used_reg <= '0;
                            gue_used_reg <= '0;
                            exact_cnt    <= '0;
                            partial_cnt  <= '0;
                        end
                    end
                    EXACT: begin
                        if (exact_hit) begin
                            exact_cnt        <= exact_cnt + 3'd1;
                            sec_used_reg[pj] <= 1'b1;
                            gue_used_reg[pj] <= 1'b1;
                        end
                        cnt_reg <= (cnt_reg[1:0] == 2'd3) ? 4'd0 : cnt_reg + 4'd1;
                    end
                    PART: begin
                        if (part_hit) begin
                            partial_cnt      <= partial_cnt + 3'd1;
                            sec_used_reg[pi] <= 1'b1;
                            gue_used_reg[pj] <= 1'b1;
                        end
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                    RESULT: begin
                        result_valid <= 1'b1;
                        tries        <= tries_inc;
                        win          <= win_next;
                        lose         <= lose_next;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
